// File: rtl/mips_regfile_sb_pkg.sv
// Shared constants for the MIPS register file and its consumers (decode,
// hazard unit): default datapath widths and the hardwired-zero register
// address.
package mips_regfile_sb_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 3;
   localparam int REG_ZERO   = 0;

endpackage

// File: rtl/mips_regfile_sb_scoreboard.sv
// Per-register busy scoreboard for the register file.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   set_en, set_reg   decode marks set_reg as having a pending producer
//   clr_en, clr_reg   write-back retires the producer of clr_reg
//   busy              current busy vector (registered)
//   busy_count        population count of busy (registered)
module mips_reg_scoreboard
   import mips_regfile_sb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_en,
   input  logic [ADDR_W-1:0]    set_reg,
   input  logic                 clr_en,
   input  logic [ADDR_W-1:0]    clr_reg,
   output logic [2**ADDR_W-1:0] busy,
   output logic [ADDR_W:0]      busy_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] next_busy;
   logic [ADDR_W:0]  next_count;

   // Set beats clear: a new producer issued in the same cycle the previous
   // one retires must keep the register pending.
   always_comb begin
      next_busy = busy;
      for (int r = 0; r < DEPTH; r++) begin
         if (set_en && set_reg == ADDR_W'(r) && !((ZERO_REG != 0) && r == REG_ZERO))
            next_busy[r] = 1'b1;
         else if (clr_en && clr_reg == ADDR_W'(r))
            next_busy[r] = 1'b0;
      end
   end

   always_comb begin
      next_count = '0;
      for (int r = 0; r < DEPTH; r++)
         next_count = next_count + (ADDR_W+1)'(next_busy[r]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= next_busy;
         busy_count <= next_count;
      end
   end

endmodule

// File: rtl/mips_regfile_sb.sv
// Two-read / one-write register file for the pipelined MIPS datapath with
// synchronous clear, optional hardwired-zero register 0, write-to-read
// bypass and a per-register busy scoreboard.
// Ports:
//   clk, reset                   clock, synchronous active-high clear
//   write_data/write_reg/signal_reg_write   write-back port (also retires busy)
//   read_reg_1/2 -> read_data_1/2, read_busy_1/2   combinational read ports
//   busy_set/busy_reg            decode marks a pending destination
//   busy_count                   registered number of busy registers
module mips_regfile_sb
   import mips_regfile_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              signal_reg_write,
   input  logic [ADDR_W-1:0] read_reg_1,
   input  logic [ADDR_W-1:0] read_reg_2,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_reg,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   output logic              read_busy_1,
   output logic              read_busy_2,
   output logic [ADDR_W:0]   busy_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              write_ok;

   // A write to register 0 is dropped entirely when it is hardwired.
   assign write_ok = signal_reg_write &&
                     !((ZERO_REG != 0) && write_reg == ADDR_W'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++)
            regs[r] <= '0;
      end else if (write_ok) begin
         regs[write_reg] <= write_data;
      end
   end

   mips_reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .set_en     (busy_set),
      .set_reg    (busy_reg),
      .clr_en     (signal_reg_write),
      .clr_reg    (write_reg),
      .busy       (busy),
      .busy_count (busy_count)
   );

   // A forwarded write also hides the busy bit it is about to clear; a
   // same-cycle busy_set only shows up after the edge.
   always_comb begin
      read_data_1 = regs[read_reg_1];
      read_busy_1 = busy[read_reg_1];
      if ((ZERO_REG != 0) && read_reg_1 == ADDR_W'(REG_ZERO)) begin
         read_data_1 = '0;
         read_busy_1 = 1'b0;
      end else if ((BYPASS != 0) && signal_reg_write && write_reg == read_reg_1) begin
         read_data_1 = write_data;
         read_busy_1 = 1'b0;
      end
   end

   always_comb begin
      read_data_2 = regs[read_reg_2];
      read_busy_2 = busy[read_reg_2];
      if ((ZERO_REG != 0) && read_reg_2 == ADDR_W'(REG_ZERO)) begin
         read_data_2 = '0;
         read_busy_2 = 1'b0;
      end else if ((BYPASS != 0) && signal_reg_write && write_reg == read_reg_2) begin
         read_data_2 = write_data;
         read_busy_2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_regfile_sb.sv
module tb_mips_regfile_sb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   // shared stimulus for the 32x8 instances (ZERO_REG=1 and ZERO_REG=0)
   logic [31:0] wd = '0;
   logic [2:0]  wr = '0;
   logic        we = 1'b0;
   logic [2:0]  rr1 = '0;
   logic [2:0]  rr2 = '0;
   logic        bs = 1'b0;
   logic [2:0]  br = '0;

   logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
   logic        rb1, rb2, nz_rb1, nz_rb2;
   logic [3:0]  bc, nz_bc;

   // stimulus for the 16-bit, 16-entry instance
   logic [15:0] w_wd = '0;
   logic [3:0]  w_wr = '0;
   logic        w_we = 1'b0;
   logic [3:0]  w_rr1 = '0;
   logic [3:0]  w_rr2 = '0;
   logic        w_bs = 1'b0;
   logic [3:0]  w_br = '0;
   logic [15:0] w_rd1, w_rd2;
   logic        w_rb1, w_rb2;
   logic [4:0]  w_bc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_regfile_sb dut (
      .clk(clk), .reset(reset),
      .write_data(wd), .write_reg(wr), .signal_reg_write(we),
      .read_reg_1(rr1), .read_reg_2(rr2),
      .busy_set(bs), .busy_reg(br),
      .read_data_1(rd1), .read_data_2(rd2),
      .read_busy_1(rb1), .read_busy_2(rb2),
      .busy_count(bc)
   );

   mips_regfile_sb #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .reset(reset),
      .write_data(wd), .write_reg(wr), .signal_reg_write(we),
      .read_reg_1(rr1), .read_reg_2(rr2),
      .busy_set(bs), .busy_reg(br),
      .read_data_1(nz_rd1), .read_data_2(nz_rd2),
      .read_busy_1(nz_rb1), .read_busy_2(nz_rb2),
      .busy_count(nz_bc)
   );

   mips_regfile_sb #(.DATA_W(16), .ADDR_W(4)) dut_w (
      .clk(clk), .reset(reset),
      .write_data(w_wd), .write_reg(w_wr), .signal_reg_write(w_we),
      .read_reg_1(w_rr1), .read_reg_2(w_rr2),
      .busy_set(w_bs), .busy_reg(w_br),
      .read_data_1(w_rd1), .read_data_2(w_rd2),
      .read_busy_1(w_rb1), .read_busy_2(w_rb2),
      .busy_count(w_bc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      reset = 1'b0;

      // test 1: write then synchronous clear
      we = 1'b1; wr = 3'd4; wd = 32'hCE7FFFF0;
      tick();
      we = 1'b0; rr1 = 3'd4;
      #1 chk("t1_pre_reset_rd1", rd1, 32'hCE7FFFF0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1 chk("t1_rd1_after_reset", rd1, 32'h0);
      chk("t1_bc_after_reset", bc, 4'd0);
      chk("t1_rb1_after_reset", rb1, 1'b0);

      // test 2: write + bypass
      rr1 = 3'd4; rr2 = 3'd2;
      we = 1'b1; wr = 3'd4; wd = 32'hCE7FFFF0;
      #1 chk("t2_bypass_rd1", rd1, 32'hCE7FFFF0);
      chk("t2_bypass_rd2", rd2, 32'h0);
      tick();
      we = 1'b0;
      #1 chk("t2_rd1", rd1, 32'hCE7FFFF0);
      chk("t2_rd2", rd2, 32'h0);

      // test 3: register 0 hardwired vs ordinary
      we = 1'b1; wr = 3'd0; wd = 32'hFFFFFFFF; bs = 1'b1; br = 3'd0; rr1 = 3'd0;
      #1 chk("t3_z_rd1_same", rd1, 32'h0);
      chk("t3_nz_rd1_bypass", nz_rd1, 32'hFFFFFFFF);
      tick();
      we = 1'b0; bs = 1'b0;
      #1 chk("t3_z_rd1", rd1, 32'h0);
      chk("t3_z_rb1", rb1, 1'b0);
      chk("t3_z_bc", bc, 4'd0);
      chk("t3_nz_rd1", nz_rd1, 32'hFFFFFFFF);
      chk("t3_nz_rb1", nz_rb1, 1'b1);
      chk("t3_nz_bc", nz_bc, 4'd1);

      // test 4: busy set, then retire with forwarding
      bs = 1'b1; br = 3'd5; rr2 = 3'd5;
      #1 chk("t4_set_not_visible", rb2, 1'b0);
      tick();
      bs = 1'b0;
      #1 chk("t4_rb2_busy", rb2, 1'b1);
      chk("t4_bc_1", bc, 4'd1);
      we = 1'b1; wr = 3'd5; wd = 32'h1234;
      #1 chk("t4_rb2_bypass_clear", rb2, 1'b0);
      chk("t4_rd2_bypass", rd2, 32'h1234);
      tick();
      we = 1'b0;
      #1 chk("t4_bc_0", bc, 4'd0);
      chk("t4_rb2_retired", rb2, 1'b0);
      chk("t4_rd2", rd2, 32'h1234);

      // test 5: set and clear collide on reg3 -> set wins
      bs = 1'b1; br = 3'd3;
      tick();
      bs = 1'b0;
      #1 chk("t5_bc_1", bc, 4'd1);
      bs = 1'b1; br = 3'd3; we = 1'b1; wr = 3'd3; wd = 32'hAA; rr1 = 3'd3;
      #1 chk("t5_rb1_same", rb1, 1'b0);
      chk("t5_rd1_same", rd1, 32'hAA);
      tick();
      bs = 1'b0; we = 1'b0;
      #1 chk("t5_rd1", rd1, 32'hAA);
      chk("t5_rb1_still_busy", rb1, 1'b1);
      chk("t5_bc_unchanged", bc, 4'd1);

      // test 6: fill scoreboard, then reset overrides busy_set
      bs = 1'b1; br = 3'd1;
      tick();
      br = 3'd2;
      tick();
      br = 3'd6;
      tick();
      bs = 1'b0; rr1 = 3'd1; rr2 = 3'd6;
      #1 chk("t6_bc_4", bc, 4'd4);
      chk("t6_rb1", rb1, 1'b1);
      chk("t6_rb2", rb2, 1'b1);
      bs = 1'b1; br = 3'd7; reset = 1'b1;
      tick();
      reset = 1'b0; bs = 1'b0; rr2 = 3'd7;
      #1 chk("t6_bc_reset", bc, 4'd0);
      chk("t6_rb1_reset", rb1, 1'b0);
      chk("t6_rb2_reset", rb2, 1'b0);
      rr1 = 3'd3;
      #1 chk("t6_rd1_reset", rd1, 32'h0);

      // 16-bit / 16-entry instance: rerun of tests 2 and 4
      w_rr1 = 4'd12; w_rr2 = 4'd2;
      w_we = 1'b1; w_wr = 4'd12; w_wd = 16'hBEEF;
      #1 chk("w2_bypass_rd1", {16'h0, w_rd1}, 32'hBEEF);
      chk("w2_bypass_rd2", {16'h0, w_rd2}, 32'h0);
      tick();
      w_we = 1'b0;
      #1 chk("w2_rd1", {16'h0, w_rd1}, 32'hBEEF);
      w_bs = 1'b1; w_br = 4'd13; w_rr2 = 4'd13;
      tick();
      w_bs = 1'b0;
      #1 chk("w4_rb2_busy", w_rb2, 1'b1);
      chk("w4_bc_1", w_bc, 5'd1);
      w_we = 1'b1; w_wr = 4'd13; w_wd = 16'h1234;
      #1 chk("w4_rb2_bypass_clear", w_rb2, 1'b0);
      chk("w4_rd2_bypass", {16'h0, w_rd2}, 32'h1234);
      tick();
      w_we = 1'b0;
      #1 chk("w4_bc_0", w_bc, 5'd0);
      chk("w4_rd2", {16'h0, w_rd2}, 32'h1234);
      chk("w4_rd1_kept", {16'h0, w_rd1}, 32'hBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
